// File: rtl/ureg_n.sv
// ureg_n: WIDTH-bit universal register with load, shift, rotate and up/down count.
// Asynchronous active-low reset to RST_VAL. The carry/shift-out flag is a one-operation pulse.
`default_nettype none

module ureg_n #(
   parameter int unsigned          WIDTH   = 8,
   parameter logic [WIDTH-1:0]     RST_VAL = '0
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             en_i,
   input  logic             clr_i,
   input  logic [2:0]       mode_i,
   input  logic [WIDTH-1:0] d_i,
   input  logic             sin_i,
   output logic [WIDTH-1:0] q_o,
   output logic             co_o,
   output logic             zero_o
);

   localparam logic [2:0] MODE_HOLD = 3'b000;
   localparam logic [2:0] MODE_LOAD = 3'b001;
   localparam logic [2:0] MODE_SHL  = 3'b010;
   localparam logic [2:0] MODE_SHR  = 3'b011;
   localparam logic [2:0] MODE_ROL  = 3'b100;
   localparam logic [2:0] MODE_ROR  = 3'b101;
   localparam logic [2:0] MODE_INC  = 3'b110;
   localparam logic [2:0] MODE_DEC  = 3'b111;

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] q_q, q_d;
   logic             co_q, co_d;

   always_comb begin
      q_d  = q_q;
      co_d = co_q;
      if (en_i) begin
         if (clr_i) begin
            // Clear goes to zero, deliberately not to RST_VAL.
            q_d  = '0;
            co_d = 1'b0;
         end else begin
            unique case (mode_i)
               MODE_HOLD: begin
                  q_d  = q_q;
                  co_d = 1'b0;
               end
               MODE_LOAD: begin
                  q_d  = d_i;
                  co_d = 1'b0;
               end
               MODE_SHL: begin
                  q_d  = {q_q[WIDTH-2:0], sin_i};
                  co_d = q_q[WIDTH-1];
               end
               MODE_SHR: begin
                  q_d  = {sin_i, q_q[WIDTH-1:1]};
                  co_d = q_q[0];
               end
               MODE_ROL: begin
                  q_d  = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                  co_d = q_q[WIDTH-1];
               end
               MODE_ROR: begin
                  q_d  = {q_q[0], q_q[WIDTH-1:1]};
                  co_d = q_q[0];
               end
               MODE_INC: begin
                  q_d  = q_q + ONE;
                  co_d = &q_q;
               end
               MODE_DEC: begin
                  q_d  = q_q - ONE;
                  co_d = ~|q_q;
               end
               default: begin
                  q_d  = q_q;
                  co_d = 1'b0;
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         q_q  <= RST_VAL;
         co_q <= 1'b0;
      end else begin
         q_q  <= q_d;
         co_q <= co_d;
      end
   end

   assign q_o    = q_q;
   assign co_o   = co_q;
   assign zero_o = ~|q_q;

endmodule

`default_nettype wire

// File: tb/tb_ureg_n.sv
// Directed self-checking bench for ureg_n: 8-bit (two reset values), 2-bit and 32-bit builds
// share one control bus; each step's expected values are hand-computed constants.
`default_nettype none

module tb_ureg_n;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en;
   logic        clr;
   logic [2:0]  mode;
   logic        sin;
   logic [7:0]  d8, d8r;
   logic [1:0]  d2;
   logic [31:0] d32;

   logic [7:0]  q8, q8r;
   logic [1:0]  q2;
   logic [31:0] q32;
   logic        co8, co8r, co2, co32;
   logic        z8, z8r, z2, z32;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ureg_n #(.WIDTH(8), .RST_VAL(8'h00)) u_dut8 (
      .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .clr_i(clr), .mode_i(mode),
      .d_i(d8), .sin_i(sin), .q_o(q8), .co_o(co8), .zero_o(z8));

   ureg_n #(.WIDTH(8), .RST_VAL(8'h5A)) u_dut8r (
      .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .clr_i(clr), .mode_i(mode),
      .d_i(d8r), .sin_i(sin), .q_o(q8r), .co_o(co8r), .zero_o(z8r));

   ureg_n #(.WIDTH(2), .RST_VAL(2'b00)) u_dut2 (
      .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .clr_i(clr), .mode_i(mode),
      .d_i(d2), .sin_i(sin), .q_o(q2), .co_o(co2), .zero_o(z2));

   ureg_n #(.WIDTH(32), .RST_VAL(32'h0)) u_dut32 (
      .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .clr_i(clr), .mode_i(mode),
      .d_i(d32), .sin_i(sin), .q_o(q32), .co_o(co32), .zero_o(z32));

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One rising edge, then settle 1 time unit before sampling.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk8(input string tag, input logic [7:0] eq, input logic eco);
      check_value({tag, " q8"},  {24'h0, q8}, {24'h0, eq});
      check_value({tag, " co8"}, {31'h0, co8}, {31'h0, eco});
      check_value({tag, " z8"},  {31'h0, z8}, {31'h0, (eq == 8'h00)});
   endtask

   initial begin
      rst_n = 1'b0; en = 1'b0; clr = 1'b0; mode = 3'b000; sin = 1'b0;
      d8 = 8'h00; d8r = 8'h00; d2 = 2'b00; d32 = 32'h0;
      #12 rst_n = 1'b1;

      // Reset value and a first load.
      en = 1'b1; mode = 3'b001; d8 = 8'h77; d8r = 8'h11;
      step();
      chk8("load77", 8'h77, 1'b0);

      // Asynchronous reset between edges.
      #2 rst_n = 1'b0;
      #1;
      chk8("async_rst", 8'h00, 1'b0);
      check_value("async_rst q8r", {24'h0, q8r}, 32'h5A);
      d8 = 8'hFF;
      step();
      chk8("edge_in_rst", 8'h00, 1'b0);
      #2 rst_n = 1'b1;
      d8 = 8'hA5;
      step();
      chk8("loadA5", 8'hA5, 1'b0);

      // Shift / rotate sequence from 81.
      d8 = 8'h81; step();
      mode = 3'b010; sin = 1'b0; step();
      chk8("shl", 8'h02, 1'b1);
      mode = 3'b101; step();
      chk8("ror", 8'h01, 1'b0);
      mode = 3'b011; sin = 1'b1; step();
      chk8("shr", 8'h80, 1'b1);
      mode = 3'b000; step();
      chk8("hold", 8'h80, 1'b0);
      mode = 3'b001; d8 = 8'h81; step();
      mode = 3'b100; step();
      chk8("rol", 8'h03, 1'b1);

      // Count up through wrap, then down through wrap.
      mode = 3'b001; d8 = 8'hFE; step();
      mode = 3'b110; step();
      chk8("inc1", 8'hFF, 1'b0);
      step();
      chk8("inc2", 8'h00, 1'b1);
      step();
      chk8("inc3", 8'h01, 1'b0);
      mode = 3'b111; step();
      chk8("dec1", 8'h00, 1'b0);
      step();
      chk8("dec2", 8'hFF, 1'b1);

      // Enable gating beats clear; clear beats mode.
      mode = 3'b001; d8 = 8'h79; step();
      mode = 3'b011; sin = 1'b0; step();
      chk8("shr_to_3C", 8'h3C, 1'b1);
      en = 1'b0; clr = 1'b1; mode = 3'b110; d8 = 8'h55; sin = 1'b1;
      step();
      chk8("en0_hold1", 8'h3C, 1'b1);
      step();
      chk8("en0_hold2", 8'h3C, 1'b1);
      en = 1'b1; clr = 1'b1; mode = 3'b001; d8 = 8'hFF;
      step();
      chk8("clr", 8'h00, 1'b0);
      clr = 1'b0;

      // Reset coincident with a count wrap on the RST_VAL=5A instance.
      mode = 3'b001; d8r = 8'hFF; step();
      check_value("pre_wrap q8r", {24'h0, q8r}, 32'hFF);
      mode = 3'b110;
      @(posedge clk);
      rst_n = 1'b0;
      #1;
      check_value("rst_wrap q8r", {24'h0, q8r}, 32'h5A);
      check_value("rst_wrap co8r", {31'h0, co8r}, 32'h0);
      #6 rst_n = 1'b1;
      #1;
      check_value("post_rel q8r", {24'h0, q8r}, 32'h5A);
      check_value("post_rel co8r", {31'h0, co8r}, 32'h0);
      step();
      check_value("first_op q8r", {24'h0, q8r}, 32'h5B);
      check_value("first_op co8r", {31'h0, co8r}, 32'h0);
      check_value("first_op z8r", {31'h0, z8r}, 32'h0);

      // Narrow and wide builds: count wrap and rotates.
      mode = 3'b001; d2 = 2'b11; d32 = 32'hFFFF_FFFF; step();
      mode = 3'b110; step();
      check_value("w2 inc wrap q",  {30'h0, q2}, 32'h0);
      check_value("w2 inc wrap co", {31'h0, co2}, 32'h1);
      check_value("w2 inc wrap z",  {31'h0, z2}, 32'h1);
      check_value("w32 inc wrap q",  q32, 32'h0);
      check_value("w32 inc wrap co", {31'h0, co32}, 32'h1);
      check_value("w32 inc wrap z",  {31'h0, z32}, 32'h1);
      mode = 3'b001; d2 = 2'b01; d32 = 32'h8000_0001; step();
      mode = 3'b100; step();
      check_value("w2 rol q",   {30'h0, q2}, 32'h2);
      check_value("w2 rol co",  {31'h0, co2}, 32'h0);
      check_value("w32 rol q",  q32, 32'h0000_0003);
      check_value("w32 rol co", {31'h0, co32}, 32'h1);
      mode = 3'b101; step();
      check_value("w2 ror q",   {30'h0, q2}, 32'h1);
      check_value("w2 ror co",  {31'h0, co2}, 32'h0);
      check_value("w32 ror q",  q32, 32'h8000_0001);
      check_value("w32 ror co", {31'h0, co32}, 32'h1);
      step();
      check_value("w2 ror2 q",  {30'h0, q2}, 32'h2);
      check_value("w2 ror2 co", {31'h0, co2}, 32'h1);
      mode = 3'b001; d2 = 2'b00; d32 = 32'h0; step();
      mode = 3'b111; step();
      check_value("w2 dec wrap q",   {30'h0, q2}, 32'h3);
      check_value("w2 dec wrap co",  {31'h0, co2}, 32'h1);
      check_value("w32 dec wrap q",  q32, 32'hFFFF_FFFF);
      check_value("w32 dec wrap co", {31'h0, co32}, 32'h1);
      mode = 3'b010; sin = 1'b0; step();
      check_value("w2 shl q",  {30'h0, q2}, 32'h2);
      check_value("w2 shl co", {31'h0, co2}, 32'h1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
